// File: rtl/water_supply_pkg.sv
// water_supply_pkg: tank state encoding and default sensor thresholds.
package water_supply_pkg;
  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_DRAINING = 2'd2;
  localparam int DEF_LEVEL_W  = 8;
  localparam int DEF_TICK_DIV = 4;
  localparam int DEF_LOW_TH   = 32;
  localparam int DEF_MID_TH   = 128;
  localparam int DEF_HIGH_TH  = 224;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter, tick on the terminal count.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == CW'(TICK_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/water_tank_emulator.sv
// water_tank_emulator: saturating tank level model with registered, fault-injectable level sensors.
module water_tank_emulator
  import water_supply_pkg::*;
#(
  parameter int LEVEL_W  = DEF_LEVEL_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int LOW_TH   = DEF_LOW_TH,
  parameter int MID_TH   = DEF_MID_TH,
  parameter int HIGH_TH  = DEF_HIGH_TH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inlet_open,
  input  logic               outlet_demand,
  input  logic [1:0]         fault_sel,
  output logic               low_level,
  output logic               mid_level,
  output logic               high_level,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         tank_state,
  output logic               overflow,
  output logic               dry_run
);
  logic               tick, full, empty, ovf_d, dry_d;
  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [2:0]         sens_q, sens_d;
  logic               ovf_q, dry_q;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );
  // The level update uses the freshly decoded state so an input change counts on the very tick that sees it.
  always_comb begin
    state_d = (inlet_open && !outlet_demand) ? ST_FILLING :
              (!inlet_open && outlet_demand) ? ST_DRAINING : ST_HOLD;
    full    = level_q == '1;
    empty   = level_q == '0;
    ovf_d   = tick && state_d == ST_FILLING && full;
    dry_d   = tick && state_d == ST_DRAINING && empty;
    level_d = (tick && state_d == ST_FILLING && !full)   ? level_q + 1'b1 :
              (tick && state_d == ST_DRAINING && !empty) ? level_q - 1'b1 : level_q;
    sens_d  = {fault_sel == 2'b01 ? 1'b0 : level_q >= LEVEL_W'(LOW_TH),
               fault_sel == 2'b10 ? 1'b0 : level_q >= LEVEL_W'(MID_TH),
               fault_sel == 2'b11 || level_q >= LEVEL_W'(HIGH_TH)};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      level_q <= '0;
      sens_q  <= '0;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      sens_q  <= sens_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
    end
  end
  assign {low_level, mid_level, high_level} = sens_q;
  assign level      = level_q;
  assign tank_state = state_q;
  assign overflow   = ovf_q;
  assign dry_run    = dry_q;
endmodule

// File: tb/tb_water_tank_emulator.sv
// tb_water_tank_emulator: directed scenarios for the tank emulator with hand-computed expectations.
module tb_water_tank_emulator;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       inlet_open = 1'b0;
  logic       outlet_demand = 1'b0;
  logic [1:0] fault_sel = 2'b00;
  logic       low_level, mid_level, high_level, overflow, dry_run;
  logic [7:0] level;
  logic [1:0] tank_state;
  int vectors = 0;
  int errors = 0;
  int ecount = 0;
  water_tank_emulator dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .inlet_open   (inlet_open),
    .outlet_demand(outlet_demand),
    .fault_sel    (fault_sel),
    .low_level    (low_level),
    .mid_level    (mid_level),
    .high_level   (high_level),
    .level        (level),
    .tank_state   (tank_state),
    .overflow     (overflow),
    .dry_run      (dry_run)
  );
  always #5 clock = ~clock;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      ecount++;
    end
    #1;
  endtask
  // Advance to just after the next tick edge; the prescaler divides by 4 and starts at 0 after reset.
  task automatic align();
    while (ecount % 4 != 0) cyc(1);
  endtask
  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({level, tank_state, low_level, mid_level, high_level, overflow, dry_run} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {level, tank_state, low_level, mid_level, high_level, overflow, dry_run});
    end
    reset_n = 1'b1;
    ecount = 0;
  endtask
  task automatic test_fill();
    inlet_open = 1'b1;
    cyc(1);
    chk("fill_state", tank_state, 1);
    cyc(127);
    chk("fill_level_128", level, 32);
    chk("fill_low_not_yet", low_level, 0);
    cyc(1);
    chk("fill_level_129", level, 32);
    chk("fill_sensors", {low_level, mid_level, high_level}, 3'b100);
  endtask
  task automatic test_saturation();
    int pulses;
    cyc(1020 - ecount);
    chk("sat_level_255", level, 255);
    chk("sat_no_ovf_yet", overflow, 0);
    cyc(4);
    chk("sat_hold_255", level, 255);
    chk("sat_ovf_pulse", overflow, 1);
    chk("sat_sensors", {low_level, mid_level, high_level}, 3'b111);
    cyc(1);
    chk("sat_ovf_single", overflow, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      pulses += int'(overflow);
      if (level !== 8'd255) begin
        errors++;
        $display("FAIL sat_no_wrap: got %0d expected 255", level);
      end
    end
    chk("sat_ovf_count", pulses, 2);
  endtask
  task automatic test_hold();
    align();
    inlet_open = 1'b0;
    outlet_demand = 1'b1;
    cyc(500);
    chk("drain_state", tank_state, 2);
    chk("drain_to_130", level, 130);
    inlet_open = 1'b1;
    cyc(12);
    chk("hold_state", tank_state, 0);
    chk("hold_level", level, 130);
    chk("hold_sensors", {low_level, mid_level, high_level}, 3'b110);
  endtask
  task automatic test_drain();
    align();
    inlet_open = 1'b0;
    outlet_demand = 1'b1;
    cyc(516);
    chk("drain_level_1", level, 1);
    cyc(4);
    chk("drain_level_0", level, 0);
    chk("drain_no_dry_yet", dry_run, 0);
    cyc(1);
    chk("drain_low_off", low_level, 0);
    cyc(3);
    chk("dry_pulse_1", dry_run, 1);
    chk("dry_hold_0", level, 0);
    cyc(1);
    chk("dry_single", dry_run, 0);
    cyc(3);
    chk("dry_pulse_2", dry_run, 1);
  endtask
  task automatic test_fault();
    align();
    outlet_demand = 1'b0;
    inlet_open = 1'b1;
    cyc(160);
    chk("fault_level_40", level, 40);
    inlet_open = 1'b0;
    cyc(1);
    chk("fault_base", {low_level, mid_level, high_level}, 3'b100);
    fault_sel = 2'b11;
    #1;
    chk("fault_latency", {low_level, mid_level, high_level}, 3'b100);
    cyc(1);
    chk("fault_high_stuck", {low_level, mid_level, high_level}, 3'b101);
    fault_sel = 2'b00;
    cyc(1);
    chk("fault_cleared", {low_level, mid_level, high_level}, 3'b100);
    fault_sel = 2'b01;
    cyc(1);
    chk("fault_low_stuck", {low_level, mid_level, high_level}, 3'b000);
    fault_sel = 2'b00;
    cyc(1);
    chk("fault_low_clear", {low_level, mid_level, high_level}, 3'b100);
  endtask
  task automatic test_reset_midfill();
    align();
    inlet_open = 1'b1;
    cyc(440);
    chk("midfill_level_150", level, 150);
    chk("midfill_sensors", {low_level, mid_level, high_level}, 3'b110);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_level", level, 0);
    chk("async_state", tank_state, 0);
    chk("async_sensors", {low_level, mid_level, high_level}, 3'b000);
    chk("async_events", {overflow, dry_run}, 0);
    #2;
    reset_n = 1'b1;
    ecount = 0;
    cyc(3);
    chk("refill_before_tick", level, 0);
    cyc(1);
    chk("refill_first_tick", level, 1);
    cyc(4);
    chk("refill_second_tick", level, 2);
  endtask
  initial begin
    test_reset();
    test_fill();
    test_saturation();
    test_hold();
    test_drain();
    test_fault();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/water_tank_emulator.md
WATER_TANK_EMULATOR -- requirements
Module: water_tank_emulator

Interface
REQ-001 SHALL have parameter LEVEL_W, default 8, width of the tank level counter.
REQ-002 SHALL have parameter TICK_DIV, default 4, clock cycles per level-update tick (>=2).
REQ-003 SHALL have parameters LOW_TH, MID_TH, HIGH_TH, defaults 32, 128, 224, sensor thresholds (0 < LOW_TH < MID_TH < HIGH_TH <= 2^LEVEL_W-1).
REQ-004 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inlet_open  input  1  inlet valve open, tank filling.
REQ-007 SHALL have port outlet_demand  input  1  consumer draw, tank draining.
REQ-008 SHALL have port fault_sel  input  2  sensor fault injection: 00 none, 01 low stuck-0, 10 mid stuck-0, 11 high stuck-1.
REQ-009 SHALL have port low_level / mid_level / high_level  output  1 each  emulated level sensors, same encoding the sensor checker consumes.
REQ-010 SHALL have port level  output  LEVEL_W  current tank level.
REQ-011 SHALL have port tank_state  output  2  FSM state code.
REQ-012 SHALL have port overflow / dry_run  output  1 each  single-cycle event pulses.

Function
REQ-013 SHALL run a prescaler counting 0..TICK_DIV-1, wrapping, asserting an internal tick in the cycle the count equals TICK_DIV-1.
REQ-014 SHALL implement states HOLD=0, FILLING=1, DRAINING=2, evaluated every cycle (not only on tick).
REQ-015 SHALL select FILLING when inlet_open=1 and outlet_demand=0, DRAINING when inlet_open=0 and outlet_demand=1, HOLD otherwise (both or neither asserted).
REQ-016 SHALL, on tick in FILLING, increment level by 1 unless level is at 2^LEVEL_W-1, in which case level holds and overflow pulses high for exactly that cycle.
REQ-017 SHALL, on tick in DRAINING, decrement level by 1 unless level is 0, in which case level holds and dry_run pulses high for exactly that cycle.
REQ-018 SHALL never wrap level; saturation at both ends is mandatory.
REQ-019 SHALL derive raw sensors as thermometer code: low = level>=LOW_TH, mid = level>=MID_TH, high = level>=HIGH_TH.
REQ-020 SHALL register sensor outputs: each reflects level one cycle after level changes.
REQ-021 SHALL apply fault_sel on the registered sensor path, one cycle latency from fault_sel change, overriding only the selected sensor.
REQ-022 SHALL produce only consistent thermometer patterns (000, 100, 110, 111 as low,mid,high) when fault_sel=00.
REQ-023 SHALL let a state change take effect on the same tick that samples it; the prescaler SHALL NOT restart on state change.

Reset
REQ-024 SHALL, while reset_n=0, force level=0, prescaler=0, tank_state=HOLD, all sensors=0, overflow=0, dry_run=0, asynchronously.
REQ-025 SHALL resume from those values on the first rising clock after reset_n deasserts, including when reset hits mid-fill.

Structure
REQ-026 SHALL place the tank_state encoding and default threshold constants in the shared water_supply_pkg package.
REQ-027 SHALL implement the prescaler as sub-module tick_prescaler (parameter TICK_DIV, output tick).

Verification
REQ-028 SHALL verify fill from reset, defaults: inlet_open=1 -> level=32 after 32 ticks (cycle 128), low_level=1 one cycle later, mid/high=0.
REQ-029 SHALL verify saturation: level=255, FILLING -> level stays 255, overflow pulses once per tick, never wraps to 0.
REQ-030 SHALL verify drain to empty: level=1, DRAINING -> level=0 next tick, further ticks pulse dry_run, low_level=0.
REQ-031 SHALL verify both inputs high at level=130 -> HOLD, level constant 130, sensors 110 held.
REQ-032 SHALL verify fault_sel=11 at level=40 -> sensors 101 next cycle (checker conflict); fault_sel=00 -> 100 next cycle.
REQ-033 SHALL verify reset_n low mid-fill at level=150 -> all outputs 0 immediately without clock edge; refill restarts from 0.
